// File: rtl/rr_counter_scheduler.sv
// Purpose: round-robin arbiter sharing one W-bit up-counter among N requesters; done pulses when a grant's interval expires.
// Latency: grant one cycle after a request is seen in IDLE; done L enabled cycles later; one IDLE cycle between grants.
// Backpressure: en low freezes the running interval; non-granted requests wait while their req stays high.
module rr_counter_scheduler #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;       // last requester served; search starts just after it
    logic [IW-1:0] idx;       // requester currently holding the counter
    logic [W-1:0]  lim;       // interval length latched at grant time

    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic [N-1:0]  pick_oh;
    logic [W-1:0]  pick_len;
    logic [W-1:0]  count_inc;

    // Rotating priority search: first set req bit at ptr+1, ptr+2, ... modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Decode the winner into a grant vector and fetch its length.
    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
        pick_len      = len[int'(pick)*W +: W];
        count_inc     = count + W'(1);
    end

    // Scheduler state machine; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= IW'(N - 1);
            idx   <= '0;
            lim   <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= pick;
                        lim   <= pick_len;
                        gnt   <= pick_oh;
                        busy  <= 1'b1;
                        count <= '0;
                        // A zero-length interval completes immediately.
                        if (pick_len == '0) begin
                            state <= DONE;
                            done  <= pick_oh;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over counting: release without a done pulse.
                    if (!req[idx]) begin
                        state <= IDLE;
                        ptr   <= idx;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (en) begin
                        count <= count_inc;
                        if (count_inc == lim) begin
                            state <= DONE;
                            done  <= gnt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= idx;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_counter_scheduler.sv
// Bench for rr_counter_scheduler: directed scenarios plus randomized traffic against a reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// The model tracks owner / count / finished-flag per cycle from the behavioural rules.
module tb_rr_counter_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic           en;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    int total = 0;
    int bad   = 0;

    rr_counter_scheduler #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .en    (en),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_owner = -1;   // requester holding the counter, -1 when idle
    int m_cnt   = 0;    // ticks counted so far
    int m_L     = 0;    // length captured at grant
    bit m_fin   = 1'b0; // interval complete this cycle (done visible)
    int m_ptr   = N - 1;

    function automatic bit req_bit(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int len_of(input logic [N*W-1:0] v, input int i);
        logic [N*W-1:0] t;
        t = v >> (i * W);
        return int'(t[W-1:0]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_fin   = 1'b0;
            m_ptr   = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (m_owner < 0 && req_bit(req, (m_ptr + k) % N))
                    m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) begin
                m_L   = len_of(len, m_owner);
                m_cnt = 0;
                m_fin = (m_L == 0);
            end
        end else if (m_fin) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_cnt   = 0;
            m_fin   = 1'b0;
        end else if (!req_bit(req, m_owner)) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end else if (en) begin
            m_cnt++;
            if (m_cnt == m_L) m_fin = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [W-1:0] v);
        len[i*W +: W] = v;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111;
        en  = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 8'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt c=%0d got %b exp 0000", c, gnt); end
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done c=%0d got %b exp 0000", c, done); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy); end
            total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count c=%0d got %0d exp 0", c, count); end
        end
        rst = 1'b0;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got %b exp 0001", gnt); end
    endtask

    task automatic test_single;
        do_reset();
        set_len(2, 8'd5);
        req = 4'b0100;
        en  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt c=%0d got %b exp 0100", c, gnt); end
            total++; if (count !== W'(c - 1)) begin bad++; $display("FAIL single_count c=%0d got %0d exp %0d", c, count, c - 1); end
            total++; if (done !== ((c == 6) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_done c=%0d got %b", c, done); end
        end
        req = '0;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_end got %b exp 0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 8'd1);
        req = 4'b1111;
        en  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            eg = ((c - 1) % 3 < 2) ? (N'(1) << (((c - 1) / 3) % N)) : '0;
            ed = ((c - 1) % 3 == 1) ? eg : '0;
            total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt c=%0d got %b exp %b", c, gnt, eg); end
            total++; if (done !== ed) begin bad++; $display("FAIL rr_done c=%0d got %b exp %b", c, done, ed); end
        end
        req = '0;
    endtask

    task automatic test_zero_len;
        do_reset();
        set_len(1, 8'd0);
        req = 4'b0010;
        en  = 1'b1;
        tick();
        req = '0;
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL zero_gnt got %b exp 0010", gnt); end
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL zero_done got %b exp 0010", done); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL zero_count got %0d exp 0", count); end
        tick();
        total++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_idle got gnt=%b done=%b busy=%b exp all zero", gnt, done, busy);
        end
    endtask

    task automatic test_pause;
        int exp_cnt [10];
        exp_cnt = '{0, 0, 1, 1, 1, 1, 1, 2, 3, 0};
        do_reset();
        set_len(0, 8'd3);
        req = 4'b0001;
        en  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            total++; if (count !== W'(exp_cnt[c])) begin bad++; $display("FAIL pause_count c=%0d got %0d exp %0d", c, count, exp_cnt[c]); end
            total++; if (done !== ((c == 8) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL pause_done c=%0d got %b", c, done); end
            en = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
            if (c == 8) req = '0;
        end
    endtask

    task automatic test_abort;
        logic [N-1:0] eg [6];
        eg = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        set_len(3, 8'd6);
        set_len(2, 8'd4);
        set_len(0, 8'd2);
        req = 4'b1000;
        en  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++; if (gnt !== eg[c]) begin bad++; $display("FAIL abort_gnt c=%0d got %b exp %b", c, gnt, eg[c]); end
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_done c=%0d got %b exp 0000", c, done); end
            if (c == 3) begin
                total++; if (count !== 8'd2) begin bad++; $display("FAIL abort_count got %0d exp 2", count); end
                req = 4'b0101;
            end
        end
        req = '0;
    endtask

    task automatic test_reset_midrun;
        do_reset();
        set_len(2, 8'd5);
        req = 4'b0100;
        en  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (count !== W'(c - 1)) begin bad++; $display("FAIL midrst_count c=%0d got %0d exp %0d", c, count, c - 1); end
        end
        rst = 1'b1;
        req = '0;
        tick();
        total++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 8'd0) begin
            bad++; $display("FAIL midrst_clear got gnt=%b done=%b busy=%b count=%0d exp all zero", gnt, done, busy, count);
        end
        rst = 1'b0;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL midrst_nodone got %b exp 0000", done); end
    endtask

    task automatic test_max_len;
        do_reset();
        set_len(0, 8'hFF);
        req = 4'b0001;
        en  = 1'b1;
        for (int c = 1; c <= 257; c++) begin
            tick();
            if (c == 256) req = '0;
            if (c <= 256) begin
                total++; if (count !== W'(c - 1)) begin bad++; $display("FAIL max_count c=%0d got %0d exp %0d", c, count, c - 1); end
                total++; if (done !== ((c == 256) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL max_done c=%0d got %b", c, done); end
            end else begin
                total++; if (busy !== 1'b0 || count !== 8'd0) begin bad++; $display("FAIL max_end got busy=%b count=%0d exp 0/0", busy, count); end
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, W'($urandom_range(0, 6)));
        for (int c = 0; c < 4000; c++) begin
            req = req ^ (N'($urandom) & N'($urandom) & N'($urandom));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0)
                    set_len(i, ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 6)));
            tick();
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            ed = m_fin ? eg : '0;
            total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, eg); end
            total++; if (done !== ed) begin bad++; $display("FAIL rnd_done c=%0d got %b exp %b", c, done, ed); end
            total++; if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, m_owner >= 0); end
            total++; if (count !== W'(m_cnt)) begin bad++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, m_cnt); end
            total++; if ($countones(gnt) > 1 || (done & ~gnt) != '0) begin
                bad++; $display("FAIL rnd_onehot c=%0d got gnt=%b done=%b", c, gnt, done);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        en  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_pause();
        test_abort();
        test_reset_midrun();
        test_max_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
